instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 95 +++++++++
 tb/tb_instr_encoder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns decoded request fields into a 32-bit word
// and queues it in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_class,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err,
  output logic [15:0] enc_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          live;
  logic [31:0]   word;
  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (in_class)
      4'd0: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      4'd1: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          word = {1'b0, in_funct7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else
          word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      end
      4'd2: word = {in_imm[31:12], in_rd, 7'b0010111};
      4'd3: word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      4'd4: word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      4'd5: word = {in_imm[31:12], in_rd, 7'b0110111};
      4'd6: word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], 7'b1100011};
      4'd7: word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      4'd8: word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      default: legal = 1'b0;
    endcase
  end

  // live holds in_ready low until the first edge after reset release
  assign in_ready  = live && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? mem[rd_ptr] : 32'h0000_0000;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err       <= 1'b0;
      enc_count <= '0;
    end else begin
      live <= 1'b1;
      err  <= accept && !legal;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && enc_count != 16'hFFFF) enc_count <= enc_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a negedge monitor keeps a scoreboard
// of expected words; scenario tasks add direct checks on handshake and status.
module tb_instr_encoder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [15:0] enc_count;

  int checks = 0;
  int errors = 0;
  int exp_enc = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err(err), .enc_count(enc_count)
  );

  function automatic logic [31:0] model(input logic [3:0] c, input logic [2:0] f3,
                                        input logic f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
    logic [31:0] w;
    w = 32'h0;
    case (c)
      4'd0, 4'd1, 4'd7: begin
        w[6:0]   = (c == 4'd0) ? 7'h03 : (c == 4'd1) ? 7'h13 : 7'h67;
        w[31:20] = imm[11:0];
        w[19:15] = rs1;
        w[14:12] = (c == 4'd7) ? 3'b000 : f3;
        w[11:7]  = rd;
        if (c == 4'd1 && (f3 == 3'd1 || f3 == 3'd5)) begin
          w[31:25] = f7 ? 7'h20 : 7'h00;
          w[24:20] = imm[4:0];
        end
      end
      4'd3: begin
        w[6:0] = 7'h23; w[31:25] = imm[11:5]; w[24:20] = rs2; w[19:15] = rs1;
        w[14:12] = f3; w[11:7] = imm[4:0];
      end
      4'd4: begin
        w[6:0] = 7'h33; w[30] = f7; w[24:20] = rs2; w[19:15] = rs1;
        w[14:12] = f3; w[11:7] = rd;
      end
      4'd2, 4'd5: begin
        w[6:0] = (c == 4'd2) ? 7'h17 : 7'h37; w[31:12] = imm[31:12]; w[11:7] = rd;
      end
      4'd6: begin
        w[6:0] = 7'h63; w[31] = imm[12]; w[30:25] = imm[10:5]; w[24:20] = rs2;
        w[19:15] = rs1; w[14:12] = f3; w[11:8] = imm[4:1]; w[7] = imm[11];
      end
      4'd8: begin
        w[6:0] = 7'h6F; w[31] = imm[20]; w[30:21] = imm[10:1]; w[20] = imm[11];
        w[19:12] = imm[19:12]; w[11:7] = rd;
      end
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // scoreboard: compare transfers and record accepted legal requests
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got %h required none", out_instr);
        end else begin
          e = sb.pop_front();
          if (out_instr !== e) begin
            errors++;
            $display("FAIL sb_order got %h required %h", out_instr, e);
          end
        end
      end
      if (in_valid && in_ready && in_class <= 4'd8) begin
        sb.push_back(model(in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm));
        if (exp_enc < 65535) exp_enc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] c, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    in_class = c; in_funct3 = f3; in_funct7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic rand_req();
    set_req(4'($urandom_range(0, 8)), 3'($urandom), 1'($urandom), 5'($urandom),
            5'($urandom), 5'($urandom), $urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    set_req(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    in_valid = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0 ||
        enc_count !== 16'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b err=%b cnt=%h instr=%h required 0 0 0 0 0",
               in_ready, out_valid, err, enc_count, out_instr);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge got %b required 0", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release got rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    set_req(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0050_0093 || enc_count !== 16'd1) begin
      errors++;
      $display("FAIL single_addi got vld=%b instr=%h cnt=%0d required 1 00500093 1",
               out_valid, out_instr, enc_count);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain got vld=%b required 0", out_valid);
    end
  endtask

  task automatic test_fill_order();
    logic [31:0] words [4];
    words = '{32'h402081B3, 32'h0020A423, 32'h123452B7, 32'h008000EF};
    out_ready = 1'b0;
    set_req(4'd4, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0);        step();
    set_req(4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);        step();
    set_req(4'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000); step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_at_three got %b required 1", in_ready);
    end
    set_req(4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);        step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_flags got rdy=%b vld=%b required 0 1", in_ready, out_valid);
    end
    set_req(4'd1, 3'd0, 1'b0, 5'd7, 5'd7, 5'd0, 32'd77);
    step(); step();
    checks++;
    if (out_instr !== words[0] || enc_count !== 16'(exp_enc)) begin
      errors++;
      $display("FAIL full_hold got instr=%h cnt=%0d required %h %0d",
               out_instr, enc_count, words[0], exp_enc);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_instr !== words[1]) begin
      errors++;
      $display("FAIL full_pop_no_push got rdy=%b instr=%h required 1 %h",
               in_ready, out_instr, words[1]);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_instr !== words[i]) begin
        errors++;
        $display("FAIL drain_word%0d got vld=%b instr=%h required 1 %h",
                 i, out_valid, out_instr, words[i]);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || enc_count !== 16'd5) begin
      errors++;
      $display("FAIL drain_empty got vld=%b cnt=%0d required 0 5", out_valid, enc_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    set_req(4'd12, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'h1);
    step();
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || out_valid !== 1'b0 || enc_count !== 16'd5) begin
      errors++;
      $display("FAIL illegal_pulse got err=%b vld=%b cnt=%0d required 1 0 5",
               err, out_valid, enc_count);
    end
    step();
    checks++;
    if (err !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear got err=%b vld=%b required 0 0", err, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lvls [2];
    int n;
    lvls = '{1, DEPTH - 1};
    foreach (lvls[j]) begin
      out_ready = 1'b0;
      for (int k = 0; k < lvls[j]; k++) begin
        rand_req(); step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
        rand_req(); step();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_lvl%0d_cyc%0d got vld=%b rdy=%b required 1 1",
                   lvls[j], k, out_valid, in_ready);
        end
      end
      in_valid = 1'b0;
      n = 0;
      for (int k = 0; k < DEPTH + 2 && out_valid; k++) begin
        step(); n++;
      end
      checks++;
      if (n !== lvls[j] || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_level got %0d words required %0d", n, lvls[j]);
      end
      out_ready = 1'b0;
    end
    checks++;
    if (enc_count !== 16'(exp_enc) || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got cnt=%0d left=%0d required %0d 0",
               enc_count, sb.size(), exp_enc);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_req(); step();
    end
    in_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_instr !== 32'h0 || enc_count !== 16'h0) begin
      errors++;
      $display("FAIL midreset_async got vld=%b rdy=%b instr=%h cnt=%0d required 0 0 0 0",
               out_valid, in_ready, out_instr, enc_count);
    end
    sb.delete();
    exp_enc = 0;
    step();
    @(negedge clk); rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || enc_count !== 16'h0) begin
      errors++;
      $display("FAIL midreset_release got vld=%b rdy=%b cnt=%0d required 0 1 0",
               out_valid, in_ready, enc_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_order();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
